cmd_framer: RTL

//  DSO-side responder for the host UART command protocol: takes bytes from the UART receiver,

---
 rtl/dso_cmd_pkg.sv | 27 ++
 rtl/cmd_framer_resp_fifo.sv | 46 ++++
 rtl/cmd_framer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dso_cmd_pkg.sv
// Shared opcodes, acknowledge bytes, command struct and FSM state types
// for the DSO host command protocol.
package dso_cmd_pkg;

  localparam logic [7:0] DUMP_CH  = 8'h01;
  localparam logic [7:0] CFG_GAIN = 8'h02;
  localparam logic [7:0] TRIG_LVL = 8'h03;
  localparam logic [7:0] TRIG_POS = 8'h04;
  localparam logic [7:0] SET_DEC  = 8'h05;
  localparam logic [7:0] TRIG_CFG = 8'h06;
  localparam logic [7:0] TRIG_SRC = 8'h07;
  localparam logic [7:0] EEP_WR   = 8'h08;
  localparam logic [7:0] EEP_RD   = 8'h09;

  localparam logic [7:0] POS_ACK  = 8'hA5;
  localparam logic [7:0] NEG_ACK  = 8'hEE;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] hi;
    logic [7:0] lo;
  } cmd_t;

  typedef enum logic [1:0] {RX_B0, RX_B1, RX_B2, RX_HOLD} rx_state_t;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;

endpackage

// File: rtl/cmd_framer_resp_fifo.sv
// Circular response byte FIFO; pointers carry an extra wrap bit so full and
// empty are told apart without a counter.
module resp_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_wr_data,
  output logic [7:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [DEPTH];
  logic        w_wr_en;
  logic        w_rd_en;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  // A push while full is dropped even if a pop frees a slot this cycle.
  assign w_wr_en   = i_push && !o_full;
  assign w_rd_en   = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/cmd_framer.sv
// Frames UART bytes into 3-byte commands and streams queued response bytes
// to the UART transmitter. Define CMD_TIMEOUT_EN to discard stalled partial commands.
module cmd_framer
  import dso_cmd_pkg::*;
#(
  parameter int RESP_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_full,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        frame_err
);

  rx_state_t  r_rx_state, w_rx_nxt;
  tx_state_t  r_tx_state, w_tx_nxt;
  cmd_t       r_cmd;
  logic       r_clr_rx_rdy;
  logic       r_cmd_rdy;
  logic [7:0] r_tx_data;
  logic       r_trmt;
  logic       r_tx_done_d;
  logic       w_take;
  logic       w_tmo_hit;
  logic       w_pop;
  logic       w_empty;
  logic [7:0] w_head;

  assign clr_rx_rdy = r_clr_rx_rdy;
  assign cmd        = r_cmd;
  assign cmd_rdy    = r_cmd_rdy;
  assign tx_data    = r_tx_data;
  assign trmt       = r_trmt;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_frame_err;
  logic          w_in_frame;

  assign w_in_frame = (r_rx_state == RX_B1) || (r_rx_state == RX_B2);
  assign w_tmo_hit  = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_err  = r_frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_in_frame && !w_take && w_tmo_hit;
      if (!w_in_frame || w_take || w_tmo_hit) r_tmo_cnt <= '0;
      else                                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
  assign w_tmo_hit    = 1'b0;
  assign frame_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RX_B0;
      r_tx_state <= TX_IDLE;
    end else begin
      r_rx_state <= w_rx_nxt;
      r_tx_state <= w_tx_nxt;
    end
  end

  // The clr_rx_rdy guard gives the UART a cycle to drop rx_rdy before the next take.
  always_comb begin
    w_rx_nxt = r_rx_state;
    w_take   = 1'b0;
    case (r_rx_state)
      RX_B0: begin
        if (rx_rdy && !r_clr_rx_rdy) begin
          w_take   = 1'b1;
          w_rx_nxt = RX_B1;
        end
      end
      RX_B1: begin
        if (rx_rdy && !r_clr_rx_rdy) begin
          w_take   = 1'b1;
          w_rx_nxt = RX_B2;
        end else if (w_tmo_hit) begin
          w_rx_nxt = RX_B0;
        end
      end
      RX_B2: begin
        if (rx_rdy && !r_clr_rx_rdy) begin
          w_take   = 1'b1;
          w_rx_nxt = RX_HOLD;
        end else if (w_tmo_hit) begin
          w_rx_nxt = RX_B0;
        end
      end
      RX_HOLD: begin
        if (clr_cmd_rdy) w_rx_nxt = RX_B0;
      end
      default: w_rx_nxt = RX_B0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd        <= '0;
      r_clr_rx_rdy <= 1'b0;
      r_cmd_rdy    <= 1'b0;
    end else begin
      r_clr_rx_rdy <= w_take;
      if (w_take) begin
        case (r_rx_state)
          RX_B0:   r_cmd.op <= rx_data;
          RX_B1:   r_cmd.hi <= rx_data;
          default: r_cmd.lo <= rx_data;
        endcase
      end
      if (w_take && (r_rx_state == RX_B2))              r_cmd_rdy <= 1'b1;
      else if ((r_rx_state == RX_HOLD) && clr_cmd_rdy)  r_cmd_rdy <= 1'b0;
    end
  end

  assign w_pop = (r_tx_state == TX_IDLE) && !w_empty;

  resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (send_resp),
    .i_pop     (w_pop),
    .i_wr_data (resp_data),
    .o_rd_data (w_head),
    .o_full    (resp_full),
    .o_empty   (w_empty)
  );

  // tx_done is a level that may still be high from the previous byte, so only its rising edge ends a byte.
  always_comb begin
    w_tx_nxt = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (!w_empty) w_tx_nxt = TX_WAIT;
      TX_WAIT: if (tx_done && !r_tx_done_d) w_tx_nxt = TX_IDLE;
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data   <= 8'h00;
      r_trmt      <= 1'b0;
      r_tx_done_d <= 1'b0;
    end else begin
      r_tx_done_d <= tx_done;
      r_trmt      <= w_pop;
      if (w_pop) r_tx_data <= w_head;
    end
  end

endmodule
